multi_ch_tick_gen: RTL and testbench

// - Parametrised successor to the fixed 1 kHz -> 1 Hz pulse divider.
// - A shared prescaler turns the system clock into a base tick strobe.
// - NUM_CH independent channels divide the base tick by a runtime-programmable ratio.
// - Each channel drives a one-cycle pulse and a 50 % square wave.
// - Feeds sensor sampling, pump timers and display/blink logic in the water-level controller.

---
 rtl/tick_gen_pkg.sv | 21 ++
 rtl/multi_ch_tick_gen_if.sv | 37 +++
 rtl/tick_channel.sv | 63 ++++++
 rtl/multi_ch_tick_gen.sv | 78 +++++++
 tb/tb_multi_ch_tick_gen.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and sizing helpers for the multi-channel tick generator.
// Defaults describe the original 1 kHz -> 1 Hz divider.
package tick_gen_pkg;

  localparam int unsigned PRESCALE_1K_TO_1HZ = 1000;
  localparam int unsigned DEF_DIV            = 1;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/multi_ch_tick_gen_if.sv
// Run-enable, configuration and tick outputs of the multi-channel tick generator.
// The master modport drives enable/config; the slave modport is the generator itself.
interface multi_ch_tick_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned CH_W   = 4
) ();

  logic              en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              base_tick;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_sq;

  modport master (
    output en,
    output cfg_we,
    output cfg_ch,
    output cfg_div,
    input  base_tick,
    input  ch_tick,
    input  ch_sq
  );

  modport slave (
    input  en,
    input  cfg_we,
    input  cfg_ch,
    input  cfg_div,
    output base_tick,
    output ch_tick,
    output ch_sq
  );

endinterface

// File: rtl/tick_channel.sv
// One divider channel: counts base ticks up to a programmable ratio and emits
// a one-cycle pulse plus a square wave toggling on every wrap.
module tick_channel #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DEF_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             base_tick,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             sq
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    sq_d   = sq_q;
    tick_d = 1'b0;
    // A config write overrides any wrap happening in the same cycle.
    if (wr) begin
      div_d = wr_div;
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (div_q == '0) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en && base_tick) begin
      if (cnt_q == div_q - DIV_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DIV_W'(DEF_DIV);
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/multi_ch_tick_gen.sv
// Shared prescaler producing a base tick, fanned out to NUM_CH programmable
// divider channels with a per-channel config write decoder.
module multi_ch_tick_gen #(
  parameter int unsigned PRESCALE = tick_gen_pkg::PRESCALE_1K_TO_1HZ,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEF_DIV  = tick_gen_pkg::DEF_DIV,
  parameter int unsigned CH_W     = 4
) (
  input logic               clk,
  input logic               rst,
  multi_ch_tick_gen_if.slave bus
);

  import tick_gen_pkg::*;

  localparam int unsigned CntW = clog2(PRESCALE);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              base_tick_q, base_tick_d;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_sq;

  always_comb begin
    cnt_d       = cnt_q;
    base_tick_d = 1'b0;
    if (bus.en) begin
      if (cnt_q == CntW'(PRESCALE - 1)) begin
        cnt_d       = '0;
        base_tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      base_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  // Out-of-range channel indices match no strobe, so such writes vanish.
  always_comb begin
    wr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.cfg_we && (bus.cfg_ch == CH_W'(k))) begin
        wr[k] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en),
      .base_tick (base_tick_q),
      .wr        (wr[g]),
      .wr_div    (bus.cfg_div),
      .tick      (ch_tick[g]),
      .sq        (ch_sq[g])
    );
  end

  assign bus.base_tick = base_tick_q;
  assign bus.ch_tick   = ch_tick;
  assign bus.ch_sq     = ch_sq;

endmodule

// File: tb/tb_multi_ch_tick_gen.sv
// Directed bench: PRESCALE=10, two channels, cycle-exact expectations per edge.
module tb_multi_ch_tick_gen;

  localparam int unsigned Prescale = 10;
  localparam int unsigned NumCh    = 2;
  localparam int unsigned DivW     = 8;
  localparam int unsigned ChW      = 4;

  logic clk;
  logic rst;

  int total;
  int bad;
  int n;
  logic [1:0] exp_sq;

  multi_ch_tick_gen_if #(
    .NUM_CH (NumCh),
    .DIV_W  (DivW),
    .CH_W   (ChW)
  ) bus ();

  multi_ch_tick_gen #(
    .PRESCALE (Prescale),
    .NUM_CH   (NumCh),
    .DIV_W    (DivW),
    .DEF_DIV  (1),
    .CH_W     (ChW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s @edge %0d: got=%0h want=%0h", tag, n, got, exp);
    end
  endtask

  // Advance one edge, then check base_tick, ch_tick and ch_sq. clr marks channels
  // whose square wave is forced low on this edge (config write or reset).
  task automatic cycle(input logic exp_bt, input logic [1:0] exp_tk, input logic [1:0] clr);
    @(posedge clk);
    #1;
    n = n + 1;
    exp_sq = (exp_sq ^ exp_tk) & ~clr;
    check_eq("base_tick", {31'd0, bus.base_tick}, {31'd0, exp_bt});
    check_eq("ch_tick", {30'd0, bus.ch_tick}, {30'd0, exp_tk});
    check_eq("ch_sq", {30'd0, bus.ch_sq}, {30'd0, exp_sq});
  endtask

  task automatic cfg_write(input logic [ChW-1:0] ch, input logic [DivW-1:0] div);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = ch;
    bus.cfg_div = div;
  endtask

  initial begin
    int m;
    logic [1:0] tk;
    total       = 0;
    bad         = 0;
    n           = 0;
    exp_sq      = 2'b00;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_div = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_base_tick", {31'd0, bus.base_tick}, 32'd0);
    check_eq("rst_ch_tick", {30'd0, bus.ch_tick}, 32'd0);
    check_eq("rst_ch_sq", {30'd0, bus.ch_sq}, 32'd0);
    rst    = 1'b0;
    bus.en = 1'b1;

    // Default div=1 on both channels: ticks follow base_tick by one cycle.
    for (int i = 1; i <= 32; i++) begin
      tk = ((i % 10 == 1) && (i > 1)) ? 2'b11 : 2'b00;
      cycle(i % 10 == 0, tk, 2'b00);
    end

    // ch1 div=3 written on edge 33.
    cfg_write(4'd1, 8'd3);
    cycle(1'b0, 2'b00, 2'b10);
    bus.cfg_we = 1'b0;
    for (int i = 34; i <= 92; i++) begin
      tk = {(i == 61) || (i == 91), i % 10 == 1};
      cycle(i % 10 == 0, tk, 2'b00);
    end

    // Freeze for 7 edges: everything shifts by 7.
    bus.en = 1'b0;
    for (int i = 93; i <= 99; i++) cycle(1'b0, 2'b00, 2'b00);
    bus.en = 1'b1;
    for (int i = 100; i <= 118; i++) begin
      m = i - 7;
      cycle(m % 10 == 0, {1'b0, m % 10 == 1}, 2'b00);
    end

    // Disable ch0.
    cfg_write(4'd0, 8'd0);
    cycle(1'b0, 2'b00, 2'b01);
    bus.cfg_we = 1'b0;
    for (int i = 120; i <= 127; i++) begin
      m = i - 7;
      cycle(m % 10 == 0, 2'b00, 2'b00);
    end

    // Edge 128 would wrap ch1; the write wins and restarts its count.
    cfg_write(4'd1, 8'd3);
    cycle(1'b0, 2'b00, 2'b10);
    cfg_write(4'd0, 8'd2);
    cycle(1'b0, 2'b00, 2'b01);
    cfg_write(4'd5, 8'd0);
    cycle(1'b0, 2'b00, 2'b00);
    bus.cfg_we = 1'b0;
    for (int i = 131; i <= 162; i++) begin
      m = i - 7;
      cycle(m % 10 == 0, {i == 158, i == 148}, 2'b00);
    end

    // One-cycle reset mid-count.
    rst = 1'b1;
    cycle(1'b0, 2'b00, 2'b11);
    rst = 1'b0;
    for (int i = 164; i <= 176; i++) begin
      tk = (i == 174) ? 2'b11 : 2'b00;
      cycle(i == 173, tk, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
